motion_vector_selector: RTL and testbench
=========================================

Name: motion_vector_selector

Overview:
- Downstream stage of the SAD datapath: consumes the serialized stream of candidate SADs produced by the PE array under control-unit sequencing.
- Tracks the running minimum SAD across one full search (CAND_X*CAND_Y candidates) and the raster position of that minimum.
- Converts the winning position into a signed motion vector.
- Presents the result with a done/ack handshake to the frame-level controller.

Parameters:
- SAD_WIDTH, 16, width of one SAD value (256 pixels * 255 max = 65280 fits).
- CAND_X, 16, horizontal candidate positions per search (31-wide window minus 16-wide block, plus 1).
- CAND_Y, 16, vertical candidate positions per search.
- MV_WIDTH, 5, width of each signed motion-vector component.
- MV_OFFSET, 8, position subtracted from raw x/y to form the signed vector.

Ports:
- in_clk  input  1  system clock, rising edge.
- in_rst_n  input  1  reset, asynchronous assert, active-low.
- in_start  input  1  single-cycle pulse; begins a new search.
- in_sad_valid  input  1  in_sad holds a candidate SAD this cycle.
- in_sad  input  SAD_WIDTH  candidate SAD, delivered in raster order (x fastest).
- in_ack  input  1  consumer accepts the result.
- out_busy  output  1  high in ACCUM.
- out_done  output  1  result valid; held until acked.
- out_best_sad  output  SAD_WIDTH  minimum SAD of the search.
- out_mv_x  output  MV_WIDTH  signed x component, two's complement.
- out_mv_y  output  MV_WIDTH  signed y component, two's complement.
- out_overrun  output  1  sticky error flag; see Behaviour.

Behaviour:
- Reset values (in_rst_n low, asynchronous):
  - FSM to IDLE.
  - Candidate counter, x/y position counters, best_x and best_y to 0.
  - best_sad to all ones.
  - All outputs 0, except out_best_sad, which is all ones.
- FSM state IDLE:
  - in_start moves to ACCUM next cycle.
  - Entering ACCUM loads best_sad to all ones and zeroes the counters.
  - in_sad_valid is ignored.
- FSM state ACCUM:
  - Each in_sad_valid cycle consumes one candidate at the current (x,y).
  - If in_sad < best_sad, best_sad/best_x/best_y update. Comparison is strictly less, so the earliest candidate wins ties.
  - x increments; on x==CAND_X-1, x wraps to 0 and y increments.
  - in_start is ignored.
  - On the cycle consuming candidate CAND_X*CAND_Y-1, the comparison includes that candidate, and the next state is DONE.
- FSM state DONE:
  - out_done=1.
  - out_best_sad = best_sad.
  - out_mv_x = best_x - MV_OFFSET and out_mv_y = best_y - MV_OFFSET, sign-extended/truncated to MV_WIDTH.
  - Outputs are registered and stable for the whole of DONE.
  - in_ack moves to IDLE next cycle and clears out_done.
  - in_ack together with in_start in the same cycle moves directly to ACCUM; out_done drops, and the new search starts that next cycle.
- Latency: out_done rises exactly 1 cycle after the final valid sample.
- Back-pressure: none on input; gaps in in_sad_valid during ACCUM are allowed and simply stall the counters.
- out_overrun (sticky until reset):
  - Sets when in_sad_valid=1 in IDLE or DONE.
  - Also sets when in_start=1 in ACCUM.
  - The offending sample or start is discarded.
- Counters:
  - Candidate index width is $clog2(CAND_X*CAND_Y).
  - x and y counter widths are $clog2(CAND_X) and $clog2(CAND_Y); no wrap beyond the final index is reachable.
- A reset asserted mid-ACCUM aborts the search; no partial result is presented.
- If every SAD equals all ones, the result is best_sad = all ones at position (0,0).

Optional Feature:
- Macro: MVSEL_ZERO_BIAS_EN.
- Defined: on an equal SAD (in_sad == best_sad), the candidate replaces the best if its L1 distance |x-MV_OFFSET|+|y-MV_OFFSET| is strictly smaller than the stored best's distance. This adds one registered L1 distance for the current best.
- Undefined: strictly-less comparison only; the earliest equal candidate is kept. No distance logic is synthesized.

Test Plan:
- Descending ramp: start, then 256 valid SADs 1000 down to 745 -> out_done 1 cycle after the last sample; best_sad=745; mv=(7,7).
- Single minimum: all SADs 500 except index 0x25 = 3 (x=5, y=2) -> best_sad=3; mv_x=-3 (5'b11101); mv_y=-6 (5'b11010).
- Ties, macro undefined: SAD 10 at indices 0 and 136 (x=8, y=8), others 50 -> mv=(-8,-8). With MVSEL_ZERO_BIAS_EN defined -> mv=(0,0).
- Gapped stream plus handshake: valid every other cycle for all 256 samples; hold in_ack low for 20 cycles -> outputs stable throughout DONE; in_ack -> IDLE; out_done=0 the next cycle.
- Protocol errors:
  - Pulse in_sad_valid in IDLE -> out_overrun=1 and the sample is ignored.
  - Pulse in_start at candidate 100 -> counting continues to 256 unaffected.
- Mid-search reset: drop in_rst_n at candidate 128 -> all outputs return to reset values immediately. A following start with a full stream of SAD 20 -> best_sad=20, mv=(-8,-8).

Source files
------------

// File: rtl/motion_vector_selector.sv
// Running-minimum SAD tracker: picks the best candidate of one raster-ordered search and reports it as a signed motion vector.
// Optional define MVSEL_ZERO_BIAS_EN: on equal SADs, prefer the candidate nearer the zero vector (L1 distance).
module motion_vector_selector #(
    parameter int SAD_WIDTH = 16,
    parameter int CAND_X    = 16,
    parameter int CAND_Y    = 16,
    parameter int MV_WIDTH  = 5,
    parameter int MV_OFFSET = 8
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    input  logic                 in_start,
    input  logic                 in_sad_valid,
    input  logic [SAD_WIDTH-1:0] in_sad,
    input  logic                 in_ack,
    output logic                 out_busy,
    output logic                 out_done,
    output logic [SAD_WIDTH-1:0] out_best_sad,
    output logic [MV_WIDTH-1:0]  out_mv_x,
    output logic [MV_WIDTH-1:0]  out_mv_y,
    output logic                 out_overrun
);

    localparam int NCAND = CAND_X * CAND_Y;
    localparam int CW    = $clog2(NCAND);
    localparam int XW    = $clog2(CAND_X);
    localparam int YW    = $clog2(CAND_Y);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]        r_cnt;
    logic [XW-1:0]        r_x;
    logic [YW-1:0]        r_y;
    logic [SAD_WIDTH-1:0] r_best_sad;
    logic [XW-1:0]        r_best_x;
    logic [YW-1:0]        r_best_y;

    logic                 r_busy;
    logic                 r_done;
    logic [SAD_WIDTH-1:0] r_out_sad;
    logic [MV_WIDTH-1:0]  r_mv_x;
    logic [MV_WIDTH-1:0]  r_mv_y;
    logic                 r_overrun;

    logic                 w_sample;
    logic                 w_last;
    logic                 w_x_last;
    logic                 w_enter_accum;
    logic                 w_take;
    logic [SAD_WIDTH-1:0] w_nb_sad;
    logic [XW-1:0]        w_nb_x;
    logic [YW-1:0]        w_nb_y;
    logic [31:0]          w_mv_x_full;
    logic [31:0]          w_mv_y_full;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic                 w_ovr_set;

    assign w_sample = (r_state == S_ACCUM) && in_sad_valid;
    assign w_last   = w_sample && (r_cnt == CW'(NCAND - 1));
    assign w_x_last = (r_x == XW'(CAND_X - 1));

    // State register
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_start) w_state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (in_ack) w_state_nxt = in_start ? S_ACCUM : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_enter_accum = (r_state != S_ACCUM) && (w_state_nxt == S_ACCUM);

`ifdef MVSEL_ZERO_BIAS_EN
    localparam int DW = $clog2(CAND_X + CAND_Y + 2 * MV_OFFSET + 1);

    logic [DW-1:0] r_best_dist;
    logic [31:0]   w_dx;
    logic [31:0]   w_dy;
    logic [DW-1:0] w_cur_dist;

    always_comb begin
        w_dx = (32'(r_x) >= 32'(MV_OFFSET)) ? 32'(r_x) - 32'(MV_OFFSET)
                                            : 32'(MV_OFFSET) - 32'(r_x);
        w_dy = (32'(r_y) >= 32'(MV_OFFSET)) ? 32'(r_y) - 32'(MV_OFFSET)
                                            : 32'(MV_OFFSET) - 32'(r_y);
        w_cur_dist = DW'(w_dx + w_dy);
        w_take = w_sample && ((in_sad < r_best_sad) ||
                              ((in_sad == r_best_sad) && (w_cur_dist < r_best_dist)));
    end

    // Seeded with the distance of (0,0) so it always matches the stored best position
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_best_dist <= DW'(2 * MV_OFFSET);
        end else if (w_enter_accum) begin
            r_best_dist <= DW'(2 * MV_OFFSET);
        end else if (w_take) begin
            r_best_dist <= w_cur_dist;
        end
    end
`else
    assign w_take = w_sample && (in_sad < r_best_sad);
`endif

    assign w_nb_sad    = w_take ? in_sad : r_best_sad;
    assign w_nb_x      = w_take ? r_x    : r_best_x;
    assign w_nb_y      = w_take ? r_y    : r_best_y;
    assign w_mv_x_full = 32'(w_nb_x) - 32'(MV_OFFSET);
    assign w_mv_y_full = 32'(w_nb_y) - 32'(MV_OFFSET);

    // Search datapath: position counters and running minimum
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_cnt      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_best_sad <= '1;
            r_best_x   <= '0;
            r_best_y   <= '0;
        end else if (w_enter_accum) begin
            r_cnt      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_best_sad <= '1;
            r_best_x   <= '0;
            r_best_y   <= '0;
        end else if (w_sample) begin
            r_cnt      <= r_cnt + CW'(1);
            r_x        <= w_x_last ? '0 : r_x + XW'(1);
            r_y        <= w_x_last ? r_y + YW'(1) : r_y;
            r_best_sad <= w_nb_sad;
            r_best_x   <= w_nb_x;
            r_best_y   <= w_nb_y;
        end
    end

    // Output logic
    always_comb begin
        w_busy_nxt = (w_state_nxt == S_ACCUM);
        w_done_nxt = (w_state_nxt == S_DONE);
        w_ovr_set  = (in_sad_valid && (r_state != S_ACCUM)) ||
                     (in_start && (r_state == S_ACCUM));
    end

    // Result registers capture the final comparison so they hold steady through DONE
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_out_sad <= '1;
            r_mv_x    <= '0;
            r_mv_y    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_overrun <= r_overrun | w_ovr_set;
            if (w_last) begin
                r_out_sad <= w_nb_sad;
                r_mv_x    <= w_mv_x_full[MV_WIDTH-1:0];
                r_mv_y    <= w_mv_y_full[MV_WIDTH-1:0];
            end
        end
    end

    assign out_busy     = r_busy;
    assign out_done     = r_done;
    assign out_best_sad = r_out_sad;
    assign out_mv_x     = r_mv_x;
    assign out_mv_y     = r_mv_y;
    assign out_overrun  = r_overrun;

endmodule

// File: tb/tb_motion_vector_selector.sv
// Directed bench for motion_vector_selector: full 16x16 searches with hand-computed winners.
module tb_motion_vector_selector;

    localparam int SW = 16;
    localparam int MW = 5;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic          ack   = 1'b0;
    logic [SW-1:0] sad   = '0;
    logic          busy;
    logic          done;
    logic [SW-1:0] best;
    logic [MW-1:0] mvx;
    logic [MW-1:0] mvy;
    logic          ovr;

    int n_tests = 0;
    int n_fail  = 0;
    logic [SW-1:0] sads [256];

    motion_vector_selector #(
        .SAD_WIDTH(SW),
        .CAND_X(16),
        .CAND_Y(16),
        .MV_WIDTH(MW),
        .MV_OFFSET(8)
    ) dut (
        .in_clk(clk),
        .in_rst_n(rst_n),
        .in_start(start),
        .in_sad_valid(valid),
        .in_sad(sad),
        .in_ack(ack),
        .out_busy(busy),
        .out_done(done),
        .out_best_sad(best),
        .out_mv_x(mvx),
        .out_mv_y(mvy),
        .out_overrun(ovr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [SW-1:0] v);
        for (int i = 0; i < 256; i++) sads[i] = v;
    endtask

    // Streams sads[]; start_at >= 0 raises a stray in_start alongside that sample
    task automatic run(input string tag, input int gap, input int start_at, input bit do_start);
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        check({tag, "_busy"}, 32'(busy), 1);
        for (int i = 0; i < 256; i++) begin
            valid = 1'b1;
            sad   = sads[i];
            start = (i == start_at);
            if (i == 255) check({tag, "_pre_done"}, 32'(done), 0);
            tick();
            valid = 1'b0;
            start = 1'b0;
            if (i < 255) repeat (gap) tick();
        end
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy_off"}, 32'(busy), 0);
    endtask

    task automatic check_result(input string tag, input int exp_sad, input int exp_x, input int exp_y);
        check({tag, "_sad"}, 32'(best), 32'(exp_sad));
        check({tag, "_mvx"}, 32'(mvx), 32'(exp_x));
        check({tag, "_mvy"}, 32'(mvy), 32'(exp_y));
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, "_ack_done"}, 32'(done), 0);
        check({tag, "_ack_busy"}, 32'(busy), 0);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sad", 32'(best), 32'hFFFF);
        check("rst_mvx", 32'(mvx), 0);
        check("rst_mvy", 32'(mvy), 0);
        check("rst_ovr", 32'(ovr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Descending ramp: last candidate (15,15) wins -> (7,7)
        for (int i = 0; i < 256; i++) sads[i] = SW'(1000 - i);
        run("ramp", 0, -1, 1'b1);
        check_result("ramp", 745, 7, 7);

        // ack with start: straight back into ACCUM
        ack   = 1'b1;
        start = 1'b1;
        tick();
        ack   = 1'b0;
        start = 1'b0;
        check("ackstart_done", 32'(done), 0);

        // Single minimum at (5,2) -> (-3,-6)
        fill(SW'(500));
        sads[37] = SW'(3);
        run("single", 0, -1, 1'b0);
        check_result("single", 3, 5'b11101, 5'b11010);
        do_ack("single");

        // Tie between (0,0) and (8,8)
        fill(SW'(50));
        sads[0]   = SW'(10);
        sads[136] = SW'(10);
        run("tie", 0, -1, 1'b1);
`ifdef MVSEL_ZERO_BIAS_EN
        check_result("tie", 10, 0, 0);
`else
        check_result("tie", 10, 5'b11000, 5'b11000);
`endif
        do_ack("tie");

        // Gapped stream, minimum at (8,12) -> (0,4), then a long ack wait
        fill(SW'(600));
        sads[200] = SW'(99);
        run("gap", 1, -1, 1'b1);
        for (int c = 0; c < 20; c++) begin
            check("hold_done", 32'(done), 1);
            check_result("hold", 99, 0, 4);
            tick();
        end
        do_ack("gap");
        tick();
        check("idle_done", 32'(done), 0);

        // Protocol errors: stray valid in IDLE, stray start mid-search
        check("ovr_pre", 32'(ovr), 0);
        valid = 1'b1;
        sad   = SW'(1);
        tick();
        valid = 1'b0;
        check("ovr_idle", 32'(ovr), 1);
        check("ovr_idle_busy", 32'(busy), 0);
        check("ovr_idle_done", 32'(done), 0);
        fill(SW'(700));
        sads[10] = SW'(50);
        run("ovr", 0, 100, 1'b1);
        check_result("ovr", 50, 2, 5'b11000);
        check("ovr_sticky", 32'(ovr), 1);
        do_ack("ovr");

        // Mid-search reset at candidate 128
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 128; i++) begin
            valid = 1'b1;
            sad   = SW'(5);
            tick();
        end
        valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 0);
        check("mid_done", 32'(done), 0);
        check("mid_sad", 32'(best), 32'hFFFF);
        check("mid_mvx", 32'(mvx), 0);
        check("mid_mvy", 32'(mvy), 0);
        check("mid_ovr", 32'(ovr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        fill(SW'(20));
        run("post", 0, -1, 1'b1);
        check_result("post", 20, 5'b11000, 5'b11000);
        do_ack("post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
